// File: rtl/ccff_loader_pkg.sv
// ccff_loader_pkg
//   Shared definitions for the configuration-chain loader:
//   - state_e        : loader FSM state encoding
//   - CRC16_POLY/INIT: CRC-16-CCITT constants used by the readback CRC
//   - crc16_step     : one serial MSB-first CRC update
package ccff_loader_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [15:0] CRC16_POLY = 16'h1021;
  localparam logic [15:0] CRC16_INIT = 16'hFFFF;

  function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic din);
    logic fb;
    fb = crc[15] ^ din;
    crc16_step = {crc[14:0], 1'b0} ^ (fb ? CRC16_POLY : 16'h0000);
  endfunction

endpackage

// File: rtl/ccff_crc16.sv
// ccff_crc16
//   Serial CRC-16-CCITT accumulator (MSB-first). init takes priority over en.
//   Ports:
//     prog_clk  in   clock
//     reset     in   synchronous active-high reset (loads CRC16_INIT)
//     init      in   reload CRC16_INIT on the next edge
//     en        in   fold din into the CRC on the next edge
//     din       in   serial data bit
//     crc       out  current CRC value
module ccff_crc16
  import ccff_loader_pkg::*;
(
  input  logic        prog_clk,
  input  logic        reset,
  input  logic        init,
  input  logic        en,
  input  logic        din,
  output logic [15:0] crc
);

  logic [15:0] crc_q;
  logic [15:0] crc_d;

  always_comb begin
    crc_d = crc_q;
    if (init) begin
      crc_d = CRC16_INIT;
    end else if (en) begin
      crc_d = crc16_step(crc_q, din);
    end
  end

  always_ff @(posedge prog_clk) begin
    if (reset) begin
      crc_q <= CRC16_INIT;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign crc = crc_q;

endmodule

// File: rtl/ccff_loader.sv
// ccff_loader
//   Serialises bitstream words MSB-first onto the configuration flip-flop
//   chain of the tile array, gating prog_clk via ccff_shift_en so the chain
//   only advances on valid bits. Stops after exactly CHAIN_LEN bits.
//   Optional feature macro: CCFF_READBACK_EN adds readback_crc, a CRC-16-CCITT
//   of the bits returning on ccff_tail while the chain shifts.
//   Ports:
//     prog_clk       in   clock
//     reset          in   synchronous active-high reset
//     start          in   begin a load (ignored while loading)
//     cfg_word       in   bitstream word, MSB shifted first
//     cfg_valid      in   cfg_word valid
//     cfg_ready      out  word accepted when cfg_valid && cfg_ready
//     ccff_head      out  serial data into the chain head
//     ccff_shift_en  out  chain captures ccff_head on the next edge when high
//     ccff_tail      in   serial data from the chain tail (readback only)
//     busy           out  load in progress
//     done           out  CHAIN_LEN bits shifted; sticky until start/reset
//     bits_left      out  bits still to shift
//     readback_crc   out  (CCFF_READBACK_EN only) CRC of returned tail bits
//
//   state | meaning
//   IDLE  | after reset, waiting for start
//   LOAD  | fetching words and shifting bits onto the chain
//   DONE  | all CHAIN_LEN bits shifted, waiting for start
module ccff_loader
  import ccff_loader_pkg::*;
#(
  parameter  int CHAIN_LEN = 1024,
  parameter  int WORD_W    = 32,
  localparam int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
  input  logic              prog_clk,
  input  logic              reset,
  input  logic              start,
  input  logic [WORD_W-1:0] cfg_word,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  output logic              ccff_head,
  output logic              ccff_shift_en,
  input  logic              ccff_tail,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  bits_left
`ifdef CCFF_READBACK_EN
  ,
  output logic [15:0]       readback_crc
`endif
);

  localparam int SC_W = $clog2(WORD_W + 1);

  state_e            state_q, state_d;
  logic              hold_full_q, hold_full_d;
  logic [WORD_W-1:0] hold_word_q, hold_word_d;
  logic [WORD_W-1:0] shf_word_q, shf_word_d;
  logic [SC_W-1:0]   shf_cnt_q, shf_cnt_d;
  logic [CNT_W-1:0]  bits_left_q, bits_left_d;
  logic              head_q, head_d;
  logic              shift_en_q, shift_en_d;
  logic              done_q, done_d;

  logic start_go;
  logic shifting;
  logic move;
  logic need_more;
  logic ready_int;
  logic accept;

  always_comb begin
    start_go  = start && (state_q != LOAD);
    shifting  = (state_q == LOAD) && (shf_cnt_q != '0) && (bits_left_q != '0);
    move      = hold_full_q &&
                ((shf_cnt_q == '0) || (shifting && (shf_cnt_q == SC_W'(1))));
    // Only fetch while the shifter cannot cover the remaining bits, so no
    // word beyond the end of the chain is ever handshaken.
    need_more = 32'(bits_left_q) > 32'(shf_cnt_q);
    ready_int = (state_q == LOAD) && !hold_full_q && need_more;
    accept    = cfg_valid && ready_int;

    state_d     = state_q;
    hold_full_d = hold_full_q;
    hold_word_d = hold_word_q;
    shf_word_d  = shf_word_q;
    shf_cnt_d   = shf_cnt_q;
    bits_left_d = bits_left_q;
    head_d      = head_q;
    shift_en_d  = 1'b0;
    done_d      = done_q;

    case (state_q)
      IDLE, DONE: begin
        if (start_go) begin
          state_d     = LOAD;
          bits_left_d = CNT_W'(CHAIN_LEN);
          done_d      = 1'b0;
          hold_full_d = 1'b0;
          shf_cnt_d   = '0;
        end
      end
      LOAD: begin
        if (bits_left_q == '0) begin
          // Leftover low bits of the final word are discarded here.
          state_d     = DONE;
          done_d      = 1'b1;
          hold_full_d = 1'b0;
          shf_cnt_d   = '0;
        end else begin
          if (shifting) begin
            head_d      = shf_word_q[WORD_W-1];
            shift_en_d  = 1'b1;
            shf_word_d  = {shf_word_q[WORD_W-2:0], 1'b0};
            shf_cnt_d   = shf_cnt_q - SC_W'(1);
            bits_left_d = bits_left_q - CNT_W'(1);
          end
          if (move) begin
            shf_word_d  = hold_word_q;
            shf_cnt_d   = SC_W'(WORD_W);
            hold_full_d = 1'b0;
          end
          if (accept) begin
            hold_word_d = cfg_word;
            hold_full_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge prog_clk) begin
    if (reset) begin
      state_q     <= IDLE;
      hold_full_q <= 1'b0;
      hold_word_q <= '0;
      shf_word_q  <= '0;
      shf_cnt_q   <= '0;
      bits_left_q <= '0;
      head_q      <= 1'b0;
      shift_en_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_full_q <= hold_full_d;
      hold_word_q <= hold_word_d;
      shf_word_q  <= shf_word_d;
      shf_cnt_q   <= shf_cnt_d;
      bits_left_q <= bits_left_d;
      head_q      <= head_d;
      shift_en_q  <= shift_en_d;
      done_q      <= done_d;
    end
  end

  assign cfg_ready     = ready_int;
  assign ccff_head     = head_q;
  assign ccff_shift_en = shift_en_q;
  assign busy          = (state_q == LOAD);
  assign done          = done_q;
  assign bits_left     = bits_left_q;

`ifdef CCFF_READBACK_EN
  ccff_crc16 u_crc16 (
    .prog_clk (prog_clk),
    .reset    (reset),
    .init     (start_go),
    .en       (shift_en_q),
    .din      (ccff_tail),
    .crc      (readback_crc)
  );
`else
  // Tail is only needed for readback; sink it without adding logic.
  logic unused_tail;
  assign unused_tail = ccff_tail;
`endif

endmodule
